tl_phase_controller: RTL and testbench



---
 rtl/tl_phase_controller.sv | 174 +++++++++++++++++
 tb/tb_tl_phase_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_controller.sv
// Intersection phase sequencer: per-phase tick timers, left-turn skip, ped truncation, emergency override.
// All outputs registered (1 clk after inputs); no backpressure, time advances only on the tick strobe.
package tl_pkg;
   typedef enum logic [3:0] {
      S0_GRN_A   = 4'd0,
      S1_YEL_A   = 4'd1,
      S2_LEFT_A  = 4'd2,
      S3_LYEL_A  = 4'd3,
      S4_GRN_B   = 4'd4,
      S5_YEL_B   = 4'd5,
      S6_LEFT_B  = 4'd6,
      S7_LYEL_B  = 4'd7,
      S8_OVR_YEL = 4'd8,
      S9_ALL_RED = 4'd9
   } state_t;
endpackage

module tl_phase_controller
   import tl_pkg::*;
#(
   parameter int unsigned GREEN_S_T = 20,
   parameter int unsigned GREEN_L_T = 8,
   parameter int unsigned YEL_T     = 3,
   parameter int unsigned ALLRED_T  = 2,
   parameter int unsigned PED_CUT_T = 5,
   parameter int unsigned TW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          left_req_a,
   input  logic          left_req_b,
   input  logic          ped_req_a,
   input  logic          ped_req_b,
   input  logic          override_req,
   output state_t        state,
   output logic [TW-1:0] timer_rem,
   output logic          ped_wait_a,
   output logic          ped_wait_b,
   output logic          phase_start
);

   localparam int unsigned TMAX = (1 << TW) - 1;

   if (GREEN_S_T < 1 || GREEN_S_T > TMAX || GREEN_L_T < 1 || GREEN_L_T > TMAX ||
       YEL_T < 1 || YEL_T > TMAX || ALLRED_T < 1 || ALLRED_T > TMAX ||
       PED_CUT_T < 1 || PED_CUT_T > TMAX) begin : g_cfg_err
      $error("tl_phase_controller: every duration must lie in 1..2^TW-1");
   end

   localparam logic [TW-1:0] T_GS  = TW'(GREEN_S_T);
   localparam logic [TW-1:0] T_GL  = TW'(GREEN_L_T);
   localparam logic [TW-1:0] T_Y   = TW'(YEL_T);
   localparam logic [TW-1:0] T_AR  = TW'(ALLRED_T);
   localparam logic [TW-1:0] T_CUT = TW'(PED_CUT_T);
   localparam logic [TW-1:0] T_ONE = TW'(1);

   function automatic logic [TW-1:0] dur(input state_t s);
      case (s)
         S0_GRN_A, S4_GRN_B:   dur = T_GS;
         S2_LEFT_A, S6_LEFT_B: dur = T_GL;
         S9_ALL_RED:           dur = T_AR;
         default:              dur = T_Y;
      endcase
   endfunction

   // next_axis: 0 = axis A (S0) is served next out of all-red, 1 = axis B (S4)
   logic          next_axis, ovr_hold, left_lat_a, left_lat_b;
   state_t        state_n;
   logic [TW-1:0] timer_n;
   logic          next_axis_n, ovr_hold_n, left_lat_a_n, left_lat_b_n;
   logic          ped_wait_a_n, ped_wait_b_n;
   logic          ovr_take, ovr_freeze, trunc;

   always_comb begin
      state_n      = state;
      timer_n      = timer_rem;
      next_axis_n  = next_axis;
      ovr_hold_n   = ovr_hold;
      left_lat_a_n = left_lat_a;
      left_lat_b_n = left_lat_b;
      ovr_take     = override_req && (state != S8_OVR_YEL) && !(state == S9_ALL_RED && ovr_hold);
      ovr_freeze   = override_req && (state == S9_ALL_RED) && ovr_hold;
      trunc        = ((state == S0_GRN_A && ped_wait_b) || (state == S4_GRN_B && ped_wait_a))
                     && (timer_rem > T_CUT);

      if (ovr_take) begin
         // Override in a normal all-red just arms the hold; elsewhere it forces the override yellow.
         ovr_hold_n = 1'b1;
         if (state == S9_ALL_RED) begin
            timer_n = T_AR;
         end else begin
            state_n = S8_OVR_YEL;
            timer_n = T_Y;
         end
      end else if (!ovr_freeze) begin
         if (state == S9_ALL_RED) ovr_hold_n = 1'b0;
         if (tick) begin
            if (timer_rem == T_ONE) begin
               case (state)
                  S0_GRN_A:  state_n = S1_YEL_A;
                  S1_YEL_A:
                     if (left_lat_a) state_n = S2_LEFT_A;
                     else begin
                        state_n      = S9_ALL_RED;
                        next_axis_n  = 1'b1;
                        left_lat_a_n = 1'b0;
                     end
                  S2_LEFT_A: state_n = S3_LYEL_A;
                  S3_LYEL_A: begin
                     state_n      = S9_ALL_RED;
                     next_axis_n  = 1'b1;
                     left_lat_a_n = 1'b0;
                  end
                  S4_GRN_B:  state_n = S5_YEL_B;
                  S5_YEL_B:
                     if (left_lat_b) state_n = S6_LEFT_B;
                     else begin
                        state_n      = S9_ALL_RED;
                        next_axis_n  = 1'b0;
                        left_lat_b_n = 1'b0;
                     end
                  S6_LEFT_B: state_n = S7_LYEL_B;
                  S7_LYEL_B: begin
                     state_n      = S9_ALL_RED;
                     next_axis_n  = 1'b0;
                     left_lat_b_n = 1'b0;
                  end
                  S8_OVR_YEL: state_n = S9_ALL_RED;
                  default:    state_n = next_axis ? S4_GRN_B : S0_GRN_A;
               endcase
               timer_n = dur(state_n);
            end else if (trunc) begin
               timer_n = T_CUT;
            end else begin
               timer_n = timer_rem - T_ONE;
            end
         end
      end

      // A request seen on the same edge as a service clear stays latched for the next cycle.
      left_lat_a_n = left_lat_a_n | left_req_a;
      left_lat_b_n = left_lat_b_n | left_req_b;
      ped_wait_a_n = (ped_wait_a || (ped_req_a && state != S0_GRN_A))
                     && !(state_n == S0_GRN_A && state != S0_GRN_A);
      ped_wait_b_n = (ped_wait_b || (ped_req_b && state != S4_GRN_B))
                     && !(state_n == S4_GRN_B && state != S4_GRN_B);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S9_ALL_RED;
         timer_rem   <= T_AR;
         ped_wait_a  <= 1'b0;
         ped_wait_b  <= 1'b0;
         phase_start <= 1'b0;
         next_axis   <= 1'b0;
         ovr_hold    <= 1'b0;
         left_lat_a  <= 1'b0;
         left_lat_b  <= 1'b0;
      end else begin
         state       <= state_n;
         timer_rem   <= timer_n;
         ped_wait_a  <= ped_wait_a_n;
         ped_wait_b  <= ped_wait_b_n;
         phase_start <= (state_n != state);
         next_axis   <= next_axis_n;
         ovr_hold    <= ovr_hold_n;
         left_lat_a  <= left_lat_a_n;
         left_lat_b  <= left_lat_b_n;
      end
   end

endmodule

// File: tb/tb_tl_phase_controller.sv
// Self-checking bench for tl_phase_controller: vector table plus hand-built multi-cycle sequences.
module tb_tl_phase_controller;
   import tl_pkg::*;

   logic       clk = 1'b0;
   logic       rst, tick, left_req_a, left_req_b, ped_req_a, ped_req_b, override_req;
   state_t     state;
   logic [7:0] timer_rem;
   logic       ped_wait_a, ped_wait_b, phase_start;

   tl_phase_controller dut (
      .clk(clk), .rst(rst), .tick(tick),
      .left_req_a(left_req_a), .left_req_b(left_req_b),
      .ped_req_a(ped_req_a), .ped_req_b(ped_req_b),
      .override_req(override_req),
      .state(state), .timer_rem(timer_rem),
      .ped_wait_a(ped_wait_a), .ped_wait_b(ped_wait_b),
      .phase_start(phase_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [3:0] st;
      logic [7:0] tm;
      logic       pwa;
      logic       pwb;
      logic       ps;
   } exp_t;

   typedef struct {
      logic       tk;
      logic [3:0] st;
      int         tm;
      logic       ps;
   } vec_t;

   exp_t  sb[$];
   vec_t  tbl[6];
   int    n_cmp = 0;
   int    n_bad = 0;
   string tag;
   logic  exp_pwa = 1'b0;
   logic  exp_pwb = 1'b0;

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_empty: got no expectation, required one");
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || timer_rem !== e.tm || ped_wait_a !== e.pwa ||
          ped_wait_b !== e.pwb || phase_start !== e.ps) begin
         n_bad++;
         $display("FAIL %s: got st=%0d tm=%0d pwa=%b pwb=%b ps=%b, want st=%0d tm=%0d pwa=%b pwb=%b ps=%b",
                  e.nm, state, timer_rem, ped_wait_a, ped_wait_b, phase_start,
                  e.st, e.tm, e.pwa, e.pwb, e.ps);
      end
   endtask

   // Push the expectation for the coming edge, clock once, then compare.
   task automatic step(input logic [3:0] es, input int et, input logic eps);
      exp_t e;
      e.nm  = tag;
      e.st  = es;
      e.tm  = et[7:0];
      e.pwa = exp_pwa;
      e.pwb = exp_pwb;
      e.ps  = eps;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic ticks(input logic [3:0] st, input int cur, input int n);
      tick = 1'b1;
      for (int k = 1; k <= n; k++) begin
         tag = $sformatf("count_s%0d_t%0d", st, cur - k);
         step(st, cur - k, 1'b0);
      end
      tick = 1'b0;
   endtask

   // Tick from timer value cur down through expiry into nxt.
   task automatic count_to(input logic [3:0] st, input int cur, input logic [3:0] nxt, input int nd);
      ticks(st, cur, cur - 1);
      tick = 1'b1;
      if (nxt == 4'd0 && st != 4'd0) exp_pwa = 1'b0;
      if (nxt == 4'd4 && st != 4'd4) exp_pwb = 1'b0;
      tag = $sformatf("enter_s%0d_from_s%0d", nxt, st);
      step(nxt, nd, 1'b1);
      tick = 1'b0;
   endtask

   initial begin
      tbl[0] = '{tk: 1'b0, st: 4'd9, tm: 2,  ps: 1'b0};
      tbl[1] = '{tk: 1'b1, st: 4'd9, tm: 1,  ps: 1'b0};
      tbl[2] = '{tk: 1'b0, st: 4'd9, tm: 1,  ps: 1'b0};
      tbl[3] = '{tk: 1'b1, st: 4'd0, tm: 20, ps: 1'b1};
      tbl[4] = '{tk: 1'b0, st: 4'd0, tm: 20, ps: 1'b0};
      tbl[5] = '{tk: 1'b1, st: 4'd0, tm: 19, ps: 1'b0};

      rst = 1'b1; tick = 1'b0; left_req_a = 1'b0; left_req_b = 1'b0;
      ped_req_a = 1'b0; ped_req_b = 1'b0; override_req = 1'b0;
      #2;
      tag = "reset_0"; step(4'd9, 2, 1'b0);
      tag = "reset_1"; step(4'd9, 2, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         tick = tbl[i].tk;
         tag  = $sformatf("vec_%0d", i);
         step(tbl[i].st, tbl[i].tm, tbl[i].ps);
      end
      tick = 1'b0;

      // Plain cycle with no left demand: S2 skipped, axis B next.
      count_to(4'd0, 19, 4'd1, 3);
      count_to(4'd1, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd4, 20);
      count_to(4'd4, 20, 4'd5, 3);
      count_to(4'd5, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd0, 20);

      // One-cycle left pulse is latched and served, then latch is gone next A cycle.
      left_req_a = 1'b1;
      tag = "left_a_pulse"; step(4'd0, 20, 1'b0);
      left_req_a = 1'b0;
      count_to(4'd0, 20, 4'd1, 3);
      count_to(4'd1, 3, 4'd2, 8);
      count_to(4'd2, 8, 4'd3, 3);
      count_to(4'd3, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd4, 20);
      count_to(4'd4, 20, 4'd5, 3);
      count_to(4'd5, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd0, 20);
      count_to(4'd0, 20, 4'd1, 3);
      count_to(4'd1, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd4, 20);
      count_to(4'd4, 20, 4'd5, 3);
      count_to(4'd5, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd0, 20);

      // Ped call on B truncates A green; ped_req_a during S0 is ignored.
      ticks(4'd0, 20, 5);
      ped_req_b = 1'b1; ped_req_a = 1'b1; exp_pwb = 1'b1;
      tag = "ped_b_latch"; step(4'd0, 15, 1'b0);
      ped_req_b = 1'b0; ped_req_a = 1'b0;
      tick = 1'b1;
      tag = "ped_truncate"; step(4'd0, 5, 1'b0);
      tick = 1'b0;
      count_to(4'd0, 5, 4'd1, 3);
      count_to(4'd1, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd4, 20);

      // Override mid-green B, hold in all-red, resume on axis B.
      ticks(4'd4, 20, 8);
      override_req = 1'b1;
      tag = "ovr_enter_s8"; step(4'd8, 3, 1'b1);
      count_to(4'd8, 3, 4'd9, 2);
      tick = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tag = $sformatf("ovr_hold_%0d", k);
         step(4'd9, 2, 1'b0);
      end
      override_req = 1'b0;
      count_to(4'd9, 2, 4'd4, 20);

      // Override beats a same-cycle expiry tick in S1.
      count_to(4'd4, 20, 4'd5, 3);
      count_to(4'd5, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd0, 20);
      count_to(4'd0, 20, 4'd1, 3);
      ticks(4'd1, 3, 2);
      tick = 1'b1; override_req = 1'b1;
      tag = "ovr_vs_tick_s1"; step(4'd8, 3, 1'b1);
      tick = 1'b0; override_req = 1'b0;
      count_to(4'd8, 3, 4'd9, 2);
      count_to(4'd9, 2, 4'd0, 20);

      // Override raised during a normal all-red: stay put, freeze, then resume.
      count_to(4'd0, 20, 4'd1, 3);
      count_to(4'd1, 3, 4'd9, 2);
      tick = 1'b1; override_req = 1'b1;
      tag = "ovr_in_s9_a"; step(4'd9, 2, 1'b0);
      tag = "ovr_in_s9_b"; step(4'd9, 2, 1'b0);
      tick = 1'b0; override_req = 1'b0;
      count_to(4'd9, 2, 4'd4, 20);

      // Reset in the middle of S6.
      left_req_b = 1'b1;
      tag = "left_b_pulse"; step(4'd4, 20, 1'b0);
      left_req_b = 1'b0;
      count_to(4'd4, 20, 4'd5, 3);
      count_to(4'd5, 3, 4'd6, 8);
      ticks(4'd6, 8, 3);
      ped_req_a = 1'b1; exp_pwa = 1'b1;
      tag = "ped_a_latch_s6"; step(4'd6, 5, 1'b0);
      ped_req_a = 1'b0;
      rst = 1'b1; exp_pwa = 1'b0; exp_pwb = 1'b0;
      tag = "reset_mid_s6"; step(4'd9, 2, 1'b0);
      rst = 1'b0;
      count_to(4'd9, 2, 4'd0, 20);
      count_to(4'd0, 20, 4'd1, 3);
      count_to(4'd1, 3, 4'd9, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
